motoro3_step_sequencer: RTL and testbench

//  Commutation sequencer upstream of the three line generators. Produces the shared
//  25-bit step-period counter m3cnt, its end-of-period flag m3cntLast1, the PWM sub-step

---
 rtl/motoro3_step_sequencer.sv | 164 ++++++++++++++++
 tb/tb_motoro3_step_sequencer.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/motoro3_step_sequencer.sv
// Commutation sequencer for a three-line motor: period counter, PWM sub-step index and
// per-line step codes, with an IDLE/ALIGN/RUN/STOP start-up and shut-down sequence.
module motoro3_step_sequencer #(
  parameter int unsigned CNT_W       = 25,
  parameter int unsigned MIN_CNT     = 100,
  parameter int unsigned ALIGN_STEPS = 8
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic             m3r_run,
  input  logic             m3r_dirCW,
  input  logic [CNT_W-1:0] m3r_stepCNT_speedSET,
  input  logic [1:0]       m3r_stepSplitMax,
  output logic [CNT_W-1:0] m3cnt,
  output logic             m3cntLast1,
  output logic [1:0]       m3LpwmStep,
  output logic [3:0]       lgStepA,
  output logic [3:0]       lgStepB,
  output logic [3:0]       lgStepC,
  output logic             m3stepPulse,
  output logic             m3busy
);

  localparam int unsigned STEP_NUM = 12;
  localparam int unsigned LINE_OFS = STEP_NUM / 3;
  localparam int unsigned ALIGN_W  = 4;
  localparam logic [3:0]  OFF_CODE = 4'hF;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ALIGN = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   spd_eff_q, spd_eff_d;
  logic [1:0]         sub_q, sub_d;
  logic [3:0]         step_idx_q, step_idx_d;
  logic [ALIGN_W-1:0] align_q, align_d;
  logic [3:0]         lg_a_q, lg_a_d, lg_b_q, lg_b_d, lg_c_q, lg_c_d;
  logic               pulse_q, pulse_d;

  logic [CNT_W-1:0]   spd_sel_c;
  logic               last1_c;
  logic               boundary_c;

  function automatic logic [3:0] step_add(input logic [3:0] idx, input int unsigned ofs);
    logic [4:0] s;
    s = 5'(idx) + 5'(ofs);
    if (s >= 5'(STEP_NUM)) s = s - 5'(STEP_NUM);
    return s[3:0];
  endfunction

  function automatic logic [3:0] step_next(input logic [3:0] idx, input logic cw);
    if (cw) return (idx == 4'(STEP_NUM - 1)) ? 4'd0 : idx + 4'd1;
    return (idx == 4'd0) ? 4'(STEP_NUM - 1) : idx - 4'd1;
  endfunction

  assign spd_sel_c  = (m3r_stepCNT_speedSET < CNT_W'(MIN_CNT)) ? CNT_W'(MIN_CNT)
                                                                : m3r_stepCNT_speedSET;
  assign last1_c    = (state_q != ST_IDLE) && (cnt_q == spd_eff_q - CNT_W'(1));
  assign boundary_c = last1_c && (sub_q >= m3r_stepSplitMax);

  // Next-state logic; the period is latched only at step boundaries so a step is never split
  always_comb begin
    state_d    = state_q;
    cnt_d      = last1_c ? '0 : cnt_q + CNT_W'(1);
    sub_d      = sub_q;
    step_idx_d = step_idx_q;
    align_d    = align_q;
    spd_eff_d  = boundary_c ? spd_sel_c : spd_eff_q;
    pulse_d    = 1'b0;
    if (last1_c) sub_d = boundary_c ? 2'd0 : sub_q + 2'd1;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        sub_d = 2'd0;
        if (m3r_run) begin
          state_d    = ST_ALIGN;
          step_idx_d = 4'd0;
          align_d    = '0;
          spd_eff_d  = spd_sel_c;
        end
      end
      ST_ALIGN: begin
        if (!m3r_run) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          sub_d   = 2'd0;
        end else if (boundary_c) begin
          if (align_q == ALIGN_W'(ALIGN_STEPS - 1)) begin
            state_d    = ST_RUN;
            step_idx_d = step_next(step_idx_q, m3r_dirCW);
            pulse_d    = 1'b1;
          end else begin
            align_d = align_q + ALIGN_W'(1);
          end
        end
      end
      ST_RUN, ST_STOP: begin
        // A run request seen in STOP resumes RUN without disturbing the counter
        if ((state_q == ST_RUN) || m3r_run) begin
          if (boundary_c) begin
            step_idx_d = step_next(step_idx_q, m3r_dirCW);
            pulse_d    = 1'b1;
          end
          state_d = m3r_run ? ST_RUN : ST_STOP;
        end else if (boundary_c) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          sub_d   = 2'd0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d == ST_IDLE) begin
      lg_a_d = OFF_CODE;
      lg_b_d = OFF_CODE;
      lg_c_d = OFF_CODE;
    end else begin
      lg_a_d = step_idx_d;
      lg_b_d = step_add(step_idx_d, LINE_OFS);
      lg_c_d = step_add(step_idx_d, 2 * LINE_OFS);
    end
  end

  always_ff @(posedge clk) begin
    if (!nRst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      spd_eff_q  <= CNT_W'(MIN_CNT);
      sub_q      <= 2'd0;
      step_idx_q <= 4'd0;
      align_q    <= '0;
      lg_a_q     <= OFF_CODE;
      lg_b_q     <= OFF_CODE;
      lg_c_q     <= OFF_CODE;
      pulse_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      spd_eff_q  <= spd_eff_d;
      sub_q      <= sub_d;
      step_idx_q <= step_idx_d;
      align_q    <= align_d;
      lg_a_q     <= lg_a_d;
      lg_b_q     <= lg_b_d;
      lg_c_q     <= lg_c_d;
      pulse_q    <= pulse_d;
    end
  end

  assign m3cnt       = cnt_q;
  assign m3cntLast1  = last1_c;
  assign m3LpwmStep  = sub_q;
  assign lgStepA     = lg_a_q;
  assign lgStepB     = lg_b_q;
  assign lgStepC     = lg_c_q;
  assign m3stepPulse = pulse_q;
  assign m3busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_motoro3_step_sequencer.sv
// Self-checking bench for motoro3_step_sequencer: expected step codes and timing gaps are
// queued when stimulus is applied and popped as the DUT produces each step change.
`timescale 1ns/1ps
module tb_motoro3_step_sequencer;

  logic        clk = 1'b0;
  logic        nRst;
  logic        run;
  logic        dir_cw;
  logic [24:0] speed;
  logic [1:0]  split_max;
  logic [24:0] m3cnt;
  logic        last1;
  logic [1:0]  pwm_step;
  logic [3:0]  lg_a, lg_b, lg_c;
  logic        pulse;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int last_stamp = 0;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] c;
    int         gap;
  } exp_t;

  exp_t exp_q[$];
  int   gap_q[$];

  motoro3_step_sequencer dut (
    .clk                  (clk),
    .nRst                 (nRst),
    .m3r_run              (run),
    .m3r_dirCW            (dir_cw),
    .m3r_stepCNT_speedSET (speed),
    .m3r_stepSplitMax     (split_max),
    .m3cnt                (m3cnt),
    .m3cntLast1           (last1),
    .m3LpwmStep           (pwm_step),
    .lgStepA              (lg_a),
    .lgStepB              (lg_b),
    .lgStepC              (lg_c),
    .m3stepPulse          (pulse),
    .m3busy               (busy)
  );

  always #50 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #(95000 * 100);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  // Wait (bounded) for lgStepA to change; stamp is the cycle of the change
  task automatic wait_step(input int limit, output int stamp, output bit to);
    logic [3:0] prev;
    prev  = lg_a;
    to    = 1'b1;
    stamp = cyc;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (lg_a !== prev) begin
        to    = 1'b0;
        stamp = cyc;
        break;
      end
    end
  endtask

  task automatic wait_last1(input int limit, output int stamp, output bit to);
    to    = 1'b1;
    stamp = cyc;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (last1 === 1'b1) begin
        to    = 1'b0;
        stamp = cyc;
        break;
      end
    end
  endtask

  task automatic do_reset();
    nRst = 1'b0;
    run  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    nRst = 1'b1;
  endtask

  task automatic test_reset();
    nRst      = 1'b0;
    run       = 1'b0;
    dir_cw    = 1'b1;
    speed     = 25'd0;
    split_max = 2'd0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({busy, m3cnt, lg_a, lg_b, lg_c, pulse, last1, pwm_step} !==
        {1'b0, 25'd0, 4'hF, 4'hF, 4'hF, 1'b0, 1'b0, 2'd0}) begin
      errors++;
      $display("FAIL reset_values: busy=%b cnt=%0d A/B/C=%h/%h/%h pulse=%b, want 0 0 F/F/F 0",
               busy, m3cnt, lg_a, lg_b, lg_c, pulse);
    end
    nRst = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      checks++;
      if ({busy, m3cnt, lg_a, lg_b, lg_c, pulse, last1} !==
          {1'b0, 25'd0, 4'hF, 4'hF, 4'hF, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL idle_hold cycle %0d: busy=%b cnt=%0d A/B/C=%h/%h/%h, want 0 0 F/F/F",
                 i, busy, m3cnt, lg_a, lg_b, lg_c);
      end
    end
  endtask

  task automatic test_cw_sequence();
    int s0, st, prev;
    bit to;
    exp_t e;
    speed     = 25'd200;
    split_max = 2'd1;
    dir_cw    = 1'b1;
    run       = 1'b1;
    @(negedge clk);
    s0 = cyc;
    checks++;
    if ({busy, m3cnt, lg_a, lg_b, lg_c} !== {1'b1, 25'd0, 4'd0, 4'd4, 4'd8}) begin
      errors++;
      $display("FAIL align_entry: busy=%b cnt=%0d A/B/C=%0d/%0d/%0d, want 1 0 0/4/8",
               busy, m3cnt, lg_a, lg_b, lg_c);
    end
    wait_last1(300, st, to);
    checks++;
    if (to || (st - s0) != 199) begin
      errors++;
      $display("FAIL first_last1: offset=%0d timeout=%b, want 199", st - s0, to);
    end
    prev = st;
    wait_last1(300, st, to);
    checks++;
    if (to || (st - prev) != 200) begin
      errors++;
      $display("FAIL last1_period: got %0d timeout=%b, want 200", st - prev, to);
    end
    for (int k = 1; k <= 12; k++)
      exp_q.push_back('{4'(k % 12), 4'((k + 4) % 12), 4'((k + 8) % 12), (k == 1) ? 3200 : 400});
    prev = s0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      wait_step(4000, st, to);
      checks++;
      if (to || {lg_a, lg_b, lg_c} !== {e.a, e.b, e.c} || (st - prev) != e.gap || pulse !== 1'b1) begin
        errors++;
        $display("FAIL cw_step: got A/B/C=%0d/%0d/%0d gap=%0d pulse=%b timeout=%b, want %0d/%0d/%0d gap=%0d pulse=1",
                 lg_a, lg_b, lg_c, st - prev, pulse, to, e.a, e.b, e.c, e.gap);
      end
      prev = st;
    end
    @(negedge clk);
    checks++;
    if (pulse !== 1'b0) begin
      errors++;
      $display("FAIL pulse_width: pulse=%b one cycle after step, want 0", pulse);
    end
  endtask

  task automatic test_clamp_and_speed_change();
    int s0, st, prev, g;
    bit to;
    do_reset();
    speed     = 25'd10;
    split_max = 2'd1;
    dir_cw    = 1'b1;
    run       = 1'b1;
    @(negedge clk);
    s0 = cyc;
    gap_q.push_back(99);
    gap_q.push_back(100);
    gap_q.push_back(300);
    gap_q.push_back(300);
    repeat (50) @(negedge clk);
    speed = 25'd300;
    prev  = s0;
    while (gap_q.size() > 0) begin
      g = gap_q.pop_front();
      wait_last1(400, st, to);
      checks++;
      if (to || (st - prev) != g) begin
        errors++;
        $display("FAIL clamp_speed_gap: got %0d timeout=%b, want %0d", st - prev, to, g);
      end
      prev = st;
    end
  endtask

  task automatic test_reverse();
    int s0, st, prev;
    bit to;
    exp_t e;
    do_reset();
    speed     = 25'd100;
    split_max = 2'd0;
    dir_cw    = 1'b1;
    run       = 1'b1;
    @(negedge clk);
    s0 = cyc;
    exp_q.push_back('{4'd1,  4'd5,  4'd9,  800});
    exp_q.push_back('{4'd2,  4'd6,  4'd10, 100});
    exp_q.push_back('{4'd3,  4'd7,  4'd11, 100});
    exp_q.push_back('{4'd2,  4'd6,  4'd10, 100});
    exp_q.push_back('{4'd1,  4'd5,  4'd9,  100});
    exp_q.push_back('{4'd0,  4'd4,  4'd8,  100});
    exp_q.push_back('{4'd11, 4'd3,  4'd7,  100});
    prev = s0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      wait_step(1200, st, to);
      checks++;
      if (to || {lg_a, lg_b, lg_c} !== {e.a, e.b, e.c} || (st - prev) != e.gap || pulse !== 1'b1) begin
        errors++;
        $display("FAIL reverse_step: got A/B/C=%0d/%0d/%0d gap=%0d pulse=%b timeout=%b, want %0d/%0d/%0d gap=%0d",
                 lg_a, lg_b, lg_c, st - prev, pulse, to, e.a, e.b, e.c, e.gap);
      end
      if (e.a == 4'd3 && dir_cw) dir_cw = 1'b0;
      prev = st;
    end
    last_stamp = prev;
  endtask

  task automatic test_stop_and_resume();
    int s0, st, prev;
    bit to, stop_busy;
    logic [24:0] c0;
    exp_t e;
    repeat (30) @(negedge clk);
    run = 1'b0;
    exp_q.push_back('{4'hF, 4'hF, 4'hF, 100});
    e = exp_q.pop_front();
    wait_step(300, st, to);
    checks++;
    if (to || {lg_a, lg_b, lg_c} !== {e.a, e.b, e.c} || (st - last_stamp) != e.gap ||
        busy !== 1'b0 || m3cnt !== 25'd0 || pulse !== 1'b0) begin
      errors++;
      $display("FAIL stop_to_idle: got A/B/C=%h/%h/%h gap=%0d busy=%b cnt=%0d pulse=%b timeout=%b, want F/F/F gap=100 0 0 0",
               lg_a, lg_b, lg_c, st - last_stamp, busy, m3cnt, pulse, to);
    end
    run = 1'b1;
    @(negedge clk);
    s0 = cyc;
    exp_q.push_back('{4'd11, 4'd3, 4'd7, 800});
    e = exp_q.pop_front();
    wait_step(1200, st, to);
    checks++;
    if (to || {lg_a, lg_b, lg_c} !== {e.a, e.b, e.c} || (st - s0) != e.gap || pulse !== 1'b1) begin
      errors++;
      $display("FAIL ccw_wrap: got A/B/C=%0d/%0d/%0d gap=%0d timeout=%b, want 11/3/7 gap=800",
               lg_a, lg_b, lg_c, st - s0, to);
    end
    prev = st;
    repeat (20) @(negedge clk);
    c0  = m3cnt;
    run = 1'b0;
    stop_busy = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (busy !== 1'b1) stop_busy = 1'b0;
    end
    run = 1'b1;
    @(negedge clk);
    checks++;
    if (m3cnt !== c0 + 25'd11 || !stop_busy || busy !== 1'b1 || lg_a !== 4'd11) begin
      errors++;
      $display("FAIL resume_no_gap: cnt=%0d busy_in_stop=%b busy=%b A=%0d, want cnt=%0d 1 1 A=11",
               m3cnt, stop_busy, busy, lg_a, c0 + 25'd11);
    end
    exp_q.push_back('{4'd10, 4'd2, 4'd6, 100});
    e = exp_q.pop_front();
    wait_step(300, st, to);
    checks++;
    if (to || {lg_a, lg_b, lg_c} !== {e.a, e.b, e.c} || (st - prev) != e.gap || pulse !== 1'b1) begin
      errors++;
      $display("FAIL resume_step: got A/B/C=%0d/%0d/%0d gap=%0d timeout=%b, want 10/2/6 gap=100",
               lg_a, lg_b, lg_c, st - prev, to);
    end
  endtask

  task automatic test_reset_midrun();
    repeat (37) @(negedge clk);
    nRst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, m3cnt, lg_a, lg_b, lg_c, pulse, last1, pwm_step} !==
        {1'b0, 25'd0, 4'hF, 4'hF, 4'hF, 1'b0, 1'b0, 2'd0}) begin
      errors++;
      $display("FAIL midrun_reset: busy=%b cnt=%0d A/B/C=%h/%h/%h pulse=%b, want 0 0 F/F/F 0",
               busy, m3cnt, lg_a, lg_b, lg_c, pulse);
    end
    nRst = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, m3cnt, lg_a, lg_b, lg_c} !== {1'b1, 25'd0, 4'd0, 4'd4, 4'd8}) begin
      errors++;
      $display("FAIL realign_after_reset: busy=%b cnt=%0d A/B/C=%0d/%0d/%0d, want 1 0 0/4/8",
               busy, m3cnt, lg_a, lg_b, lg_c);
    end
  endtask

  initial begin
    test_reset();
    test_cw_sequence();
    test_clamp_and_speed_change();
    test_reverse();
    test_stop_and_resume();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
